// File: rtl/pc_fetch_seq_if.sv
// Program-ROM bus between the fetch sequencer (master) and the ROM (slave).
interface pc_fetch_seq_if #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INSTR_W = 8
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/pc_fetch_seq.sv
// Program counter and two-phase FETCH/EXEC instruction-fetch sequencer.
// Optional hardware call/return stack enabled by defining PC_CALL_STACK_EN;
// without it call/ret are ignored and the stack outputs are tied to 0.
module pc_fetch_seq #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned INSTR_W     = 8,
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  pc_fetch_seq_if.master                    rom,
  input  logic                              jump,
  input  logic                              call,
  input  logic                              ret,
  input  logic [ADDR_W-1:0]                 jump_addr,
  output logic [ADDR_W-1:0]                 pc,
  output logic                              phase,
  output logic [OPCODE_W-1:0]               instr,
  output logic [INSTR_W-OPCODE_W-1:0]       oprnd,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  stack_level,
  output logic                              stack_ovf,
  output logic                              stack_unf
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} phase_t;

  phase_t             phase_q;
  logic [INSTR_W-1:0] fetch_q;

  // ROM is addressed directly by the program counter
  assign rom.rom_addr = pc;
  assign phase        = (phase_q == EXEC);
  assign instr        = fetch_q[INSTR_W-1 -: OPCODE_W];
  assign oprnd        = fetch_q[INSTR_W-OPCODE_W-1:0];

`ifdef PC_CALL_STACK_EN
  localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [LVL_W-1:0]  level_q;
  logic              ovf_q;
  logic              unf_q;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign push_idx    = IDX_W'(level_q);
  assign pop_idx     = IDX_W'(level_q - LVL_W'(1));
  assign stack_level = level_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

  // Phase machine, PC update and call stack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= FETCH;
      pc      <= '0;
      fetch_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_mem[i] <= '0;
    end else if (enable) begin
      case (phase_q)
        FETCH: begin
          fetch_q <= rom.rom_data;
          pc      <= pc + ADDR_W'(1);
          phase_q <= EXEC;
        end
        EXEC: begin
          phase_q <= FETCH;
          if (ret) begin
            if (level_q != '0) begin
              pc      <= stack_mem[pop_idx];
              level_q <= level_q - LVL_W'(1);
            end else begin
              unf_q <= 1'b1;
            end
          end else if (call) begin
            if (level_q < LVL_W'(STACK_DEPTH)) begin
              stack_mem[push_idx] <= pc;
              pc                  <= jump_addr;
              level_q             <= level_q + LVL_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (jump) begin
            pc <= jump_addr;
          end
        end
        default: phase_q <= FETCH;
      endcase
    end
  end
`else
  logic unused_ctl;

  assign unused_ctl  = ^{call, ret};
  assign stack_level = '0;
  assign stack_ovf   = 1'b0;
  assign stack_unf   = 1'b0;

  // Phase machine and PC update (jump only)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= FETCH;
      pc      <= '0;
      fetch_q <= '0;
    end else if (enable) begin
      case (phase_q)
        FETCH: begin
          fetch_q <= rom.rom_data;
          pc      <= pc + ADDR_W'(1);
          phase_q <= EXEC;
        end
        EXEC: begin
          phase_q <= FETCH;
          if (jump) pc <= jump_addr;
        end
        default: phase_q <= FETCH;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Self-checking bench for pc_fetch_seq against a queue-based behavioural model.
module tb_pc_fetch_seq;
  localparam int unsigned ADDR_W = 12, INSTR_W = 8, OPCODE_W = 4, DEPTH = 4;
`ifdef PC_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, jump, call, ret;
  logic [11:0] jump_addr;
  logic [11:0] pc;
  logic        phase;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [2:0]  stack_level;
  logic        stack_ovf, stack_unf;

  logic [7:0]  rom_mem [4096];

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [11:0] m_pc;
  bit          m_phase;
  logic [7:0]  m_word;
  logic [11:0] m_stack [$];
  bit          m_ovf, m_unf;

  pc_fetch_seq_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) rom_bus ();
  assign rom_bus.rom_data = rom_mem[rom_bus.rom_addr];

  pc_fetch_seq #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rom(rom_bus.master),
    .jump(jump), .call(call), .ret(ret), .jump_addr(jump_addr),
    .pc(pc), .phase(phase), .instr(instr), .oprnd(oprnd),
    .stack_level(stack_level), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0; m_phase = 1'b0; m_word = '0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step(input logic en, j, c, r, input logic [11:0] a);
    if (en) begin
      if (!m_phase) begin
        m_word  = rom_mem[m_pc];
        m_pc    = m_pc + 12'd1;
        m_phase = 1'b1;
      end else begin
        m_phase = 1'b0;
        if (STACK_EN && r) begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else m_unf = 1'b1;
        end else if (STACK_EN && c) begin
          if (m_stack.size() < DEPTH) begin m_stack.push_back(m_pc); m_pc = a; end
          else m_ovf = 1'b1;
        end else if (j) begin
          m_pc = a;
        end
      end
    end
  endtask

  task automatic tick(input logic en, j, c, r, input logic [11:0] a);
    enable = en; jump = j; call = c; ret = r; jump_addr = a;
    @(posedge clk);
    model_step(en, j, c, r, a);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; jump_addr = '0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    enable = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; jump_addr = '0;
    reset = 1'b1;
    #12;
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", pc); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL reset_phase: got %b expected 0", phase); end
    checks++; if ({instr, oprnd} !== 8'h00) begin errors++; $display("FAIL reset_fetch: got %h expected 00", {instr, oprnd}); end
    checks++; if ({stack_level, stack_ovf, stack_unf} !== 5'b0) begin errors++; $display("FAIL reset_stack: got %b expected 00000", {stack_level, stack_ovf, stack_unf}); end
    #3 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    tick(1, 0, 0, 0, '0);
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL seq_phase1: got %b expected 1", phase); end
    checks++; if (instr !== 4'hA || oprnd !== 4'h5) begin errors++; $display("FAIL seq_word0: got %h%h expected a5", instr, oprnd); end
    checks++; if (pc !== 12'h001) begin errors++; $display("FAIL seq_pc1: got %h expected 001", pc); end
    tick(1, 0, 0, 0, '0);
    tick(1, 0, 0, 0, '0);
    checks++; if (instr !== 4'h3 || oprnd !== 4'hC) begin errors++; $display("FAIL seq_word1: got %h%h expected 3c", instr, oprnd); end
    checks++; if (pc !== 12'h002) begin errors++; $display("FAIL seq_pc2: got %h expected 002", pc); end
  endtask

  task automatic test_jump();
    do_reset();
    tick(1, 0, 0, 0, '0);
    tick(1, 1, 0, 0, 12'h100);
    checks++; if (rom_bus.rom_addr !== 12'h100) begin errors++; $display("FAIL jump_addr: got %h expected 100", rom_bus.rom_addr); end
    tick(1, 0, 0, 0, '0);
    checks++; if (pc !== 12'h101) begin errors++; $display("FAIL jump_pc: got %h expected 101", pc); end
    checks++; if ({instr, oprnd} !== rom_mem[12'h100]) begin errors++; $display("FAIL jump_word: got %h expected %h", {instr, oprnd}, rom_mem[12'h100]); end
  endtask

  task automatic test_call_ret();
    do_reset();
    tick(1, 0, 0, 0, '0);
    tick(1, 1, 0, 0, 12'h010);
    tick(1, 0, 0, 0, '0);
    checks++; if (pc !== 12'h011) begin errors++; $display("FAIL call_pre_pc: got %h expected 011", pc); end
    tick(1, 0, 1, 0, 12'h200);
    checks++; if (pc !== m_pc || stack_level !== 3'(m_stack.size())) begin errors++; $display("FAIL call_push: got pc=%h lvl=%0d expected pc=%h lvl=%0d", pc, stack_level, m_pc, m_stack.size()); end
    tick(1, 0, 0, 0, '0);
    tick(1, 0, 0, 1, '0);
    checks++; if (pc !== m_pc || stack_level !== 3'(m_stack.size())) begin errors++; $display("FAIL call_pop: got pc=%h lvl=%0d expected pc=%h lvl=%0d", pc, stack_level, m_pc, m_stack.size()); end
  endtask

  task automatic test_stack_limits();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0, '0);
      tick(1, 0, 1, 0, 12'h300 + 12'(i * 16));
      checks++;
      if (pc !== m_pc || stack_level !== 3'(m_stack.size()) || stack_ovf !== m_ovf || stack_unf !== m_unf) begin
        errors++; $display("FAIL stack_call%0d: got pc=%h lvl=%0d ovf=%b unf=%b expected pc=%h lvl=%0d ovf=%b unf=%b",
          i, pc, stack_level, stack_ovf, stack_unf, m_pc, m_stack.size(), m_ovf, m_unf);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0, '0);
      tick(1, 0, 0, 1, '0);
      checks++;
      if (pc !== m_pc || stack_level !== 3'(m_stack.size()) || stack_ovf !== m_ovf || stack_unf !== m_unf) begin
        errors++; $display("FAIL stack_ret%0d: got pc=%h lvl=%0d ovf=%b unf=%b expected pc=%h lvl=%0d ovf=%b unf=%b",
          i, pc, stack_level, stack_ovf, stack_unf, m_pc, m_stack.size(), m_ovf, m_unf);
      end
    end
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, '0);
    checks++; if (stack_ovf !== m_ovf || stack_unf !== m_unf) begin errors++; $display("FAIL stack_sticky: got ovf=%b unf=%b expected ovf=%b unf=%b", stack_ovf, stack_unf, m_ovf, m_unf); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1, 0, 0, 0, '0);
    tick(1, 1, 0, 0, 12'hFFF);
    checks++; if (rom_bus.rom_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_addr: got %h expected fff", rom_bus.rom_addr); end
    tick(1, 0, 0, 0, '0);
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc: got %h expected 000", pc); end
    checks++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin errors++; $display("FAIL wrap_flags: got ovf=%b unf=%b expected 0 0", stack_ovf, stack_unf); end
  endtask

  task automatic test_enable_hold();
    do_reset();
    tick(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 12'h555);
      checks++;
      if (pc !== 12'h001 || phase !== 1'b1 || {instr, oprnd} !== m_word) begin
        errors++; $display("FAIL hold%0d: got pc=%h ph=%b word=%h expected pc=001 ph=1 word=%h", i, pc, phase, {instr, oprnd}, m_word);
      end
    end
    tick(1, 0, 0, 0, '0);
    checks++; if (pc !== 12'h001 || phase !== 1'b0) begin errors++; $display("FAIL hold_resume: got pc=%h ph=%b expected pc=001 ph=0", pc, phase); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 0, 0, 0, '0);
    tick(1, 1, 0, 0, 12'h123);
    tick(1, 0, 0, 0, '0);
    enable = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pc !== 12'h000 || phase !== 1'b0 || {instr, oprnd} !== 8'h00 || {stack_level, stack_ovf, stack_unf} !== 5'b0) begin
      errors++; $display("FAIL async_reset: got pc=%h ph=%b word=%h stk=%b expected all zero", pc, phase, {instr, oprnd}, {stack_level, stack_ovf, stack_unf});
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic en, j, c, r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(99) < 85);
      j  = ($urandom_range(99) < 25);
      c  = ($urandom_range(99) < 20);
      r  = ($urandom_range(99) < 15);
      tick(en, j, c, r, 12'($urandom));
      checks++;
      if (pc !== m_pc || rom_bus.rom_addr !== m_pc || phase !== m_phase || instr !== m_word[7:4] || oprnd !== m_word[3:0] ||
          stack_level !== 3'(m_stack.size()) || stack_ovf !== m_ovf || stack_unf !== m_unf) begin
        errors++; $display("FAIL random%0d: got pc=%h ph=%b w=%h%h lvl=%0d ovf=%b unf=%b expected pc=%h ph=%b w=%h lvl=%0d ovf=%b unf=%b",
          i, pc, phase, instr, oprnd, stack_level, stack_ovf, stack_unf, m_pc, m_phase, m_word, m_stack.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0] = 8'hA5;
    rom_mem[1] = 8'h3C;
    test_reset();
    test_sequential();
    test_jump();
    test_call_ret();
    test_stack_limits();
    test_wrap();
    test_enable_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
